// File: rtl/adc_scan_pkg.sv
// Shared types and config-word layout for the ADC scan controller.
// The serial config word is sent MSB first: {S/D, O/S, S1, S0, UNI, SLP}.
package adc_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_WAIT,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int CFG_W        = 6;
    localparam int CFG_SD_BIT   = 5;
    localparam int CFG_OS_BIT   = 4;
    localparam int CFG_SEL1_BIT = 3;
    localparam int CFG_SEL0_BIT = 2;
    localparam int CFG_UNI_BIT  = 1;
    localparam int CFG_SLP_BIT  = 0;

    // Single-ended, unipolar, no sleep; the ADC's odd/select bits scramble the channel index.
    function automatic logic [CFG_W-1:0] cfg_word(input logic [2:0] ch);
        logic [CFG_W-1:0] w;
        w               = '0;
        w[CFG_SD_BIT]   = 1'b1;
        w[CFG_OS_BIT]   = ch[0];
        w[CFG_SEL1_BIT] = ch[2];
        w[CFG_SEL0_BIT] = ch[1];
        w[CFG_UNI_BIT]  = 1'b1;
        w[CFG_SLP_BIT]  = 1'b0;
        return w;
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// SCK divider and bit counter for one serial frame; SCK is a plain flop, low half first.
// rise marks the first clk cycle of a high half, fall marks the last one (SCK drops after it).
module adc_sck_gen #(
    parameter int DATA_W  = 12,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic last_bit
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic             sck_q;
    logic             half_end;

    assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));

    // NOTE: every flop here uses non-blocking assignment so all of them see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck_q   <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            sck_q   <= 1'b0;
        end else if (half_end) begin
            div_cnt <= '0;
            sck_q   <= ~sck_q;
            if (sck_q) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign sck      = sck_q;
    assign rise     = en && sck_q && (div_cnt == '0);
    assign fall     = en && sck_q && half_end;
    assign last_bit = en && (bit_cnt == BIT_W'(DATA_W - 1));

endmodule

// File: rtl/adc_scan_ctrl.sv
// Channel-scanning controller for a serial SAR ADC that pipelines one frame:
// the data read in a frame belongs to the channel configured in the frame before.
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int NUM_CH     = 8,
    parameter int CLK_DIV    = 2,
    parameter int CONVST_CYC = 2,
    parameter int TCONV_CYC  = 80,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              continuous,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic [DATA_W-1:0] result_data,
    output logic [CH_W-1:0]   result_chan,
    output logic              result_valid,
    output logic              busy,
    output logic              ADC_CONVST,
    output logic              ADC_SCK,
    output logic              ADC_SDI,
    input  logic              ADC_SDO
);

    localparam int CNT_MAX = (CONVST_CYC > TCONV_CYC) ? CONVST_CYC : TCONV_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     tag_ch;
    logic                tag_valid;
    logic                cur_wrap;
    logic [DATA_W-1:0]   rx_sr;
    logic [CFG_W-1:0]    cfg_sr;
    logic [CFG_W-1:0]    cfg_now;
    logic                sdi_q;
    logic                sck;
    logic                sck_rise;
    logic                sck_fall;
    logic                last_bit;
    logic                conv_last;
    logic                wait_last;
    logic                mask_any;
    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     succ_ch;
    logic                succ_wrap;

    // Lowest enabled channel strictly after cur, wrapping; returns cur if none is enabled.
    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] cur,
                                                input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] res;
        logic            found;
        int              idx;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(cur) + i) % NUM_CH;
            if (!found && mask[idx]) begin
                res   = CH_W'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    adc_sck_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (state == ST_SHIFT),
        .sck      (sck),
        .rise     (sck_rise),
        .fall     (sck_fall),
        .last_bit (last_bit)
    );

    assign conv_last = (state == ST_CONV) && (cnt == CNT_W'(CONVST_CYC - 1));
    assign wait_last = (state == ST_WAIT) && (cnt == CNT_W'(TCONV_CYC - 1));
    assign mask_any  = |chan_mask;
    assign first_ch  = next_ch(CH_W'(NUM_CH - 1), chan_mask);
    assign succ_ch   = next_ch(cur_ch, chan_mask);
    assign succ_wrap = (succ_ch <= cur_ch);
    assign cfg_now   = cfg_word(3'(cur_ch));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next takes its default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if ((start || continuous) && mask_any) state_next = ST_CONV;
            ST_CONV:  if (conv_last)                         state_next = ST_WAIT;
            ST_WAIT:  if (wait_last)                         state_next = ST_SHIFT;
            ST_SHIFT: if (sck_fall && last_bit)              state_next = ST_DONE;
            ST_DONE: begin
                // A frame that configured a wrapped channel closes the pass.
                if (!mask_any || (cur_wrap && !continuous)) state_next = ST_IDLE;
                else                                        state_next = ST_CONV;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (state == ST_CONV || state == ST_WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_ch       <= '0;
            tag_ch       <= '0;
            tag_valid    <= 1'b0;
            cur_wrap     <= 1'b0;
            rx_sr        <= '0;
            cfg_sr       <= '0;
            sdi_q        <= 1'b0;
            result_data  <= '0;
            result_chan  <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (state_next == ST_CONV) begin
                        cur_ch    <= first_ch;
                        cur_wrap  <= 1'b0;
                        tag_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Preload so the first config bit is on SDI from the first SHIFT cycle.
                    if (wait_last) begin
                        sdi_q  <= cfg_now[CFG_W-1];
                        cfg_sr <= cfg_now << 1;
                    end
                end
                ST_SHIFT: begin
                    if (sck_rise) begin
                        rx_sr <= {rx_sr[DATA_W-2:0], ADC_SDO};
                    end
                    if (sck_fall) begin
                        sdi_q  <= cfg_sr[CFG_W-1];
                        cfg_sr <= cfg_sr << 1;
                    end
                end
                ST_DONE: begin
                    if (tag_valid) begin
                        result_data  <= rx_sr;
                        result_chan  <= tag_ch;
                        result_valid <= 1'b1;
                    end
                    tag_ch    <= cur_ch;
                    tag_valid <= 1'b1;
                    cur_ch    <= succ_ch;
                    cur_wrap  <= succ_wrap;
                    sdi_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign ADC_CONVST = (state == ST_CONV);
    assign ADC_SCK    = sck;
    assign ADC_SDI    = sdi_q;

endmodule
